// File: rtl/aes_decrypt_iter_ctrl.sv
// Iterative AES-128 decryptor, one inverse round per clock: accept->out_valid 11 clocks, 12 clocks/block min,
// DONE holds plaintext until out_ready. Define AES_DEC_ABORT_EN to add the abort input.
module aes_decrypt_iter_ctrl (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] ciphertext,
   input  logic [127:0] key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] plaintext,
   output logic         busy,
   output logic [3:0]   round_idx
`ifdef AES_DEC_ABORT_EN
   ,
   input  logic         abort
`endif
);

   typedef logic [15:0][7:0]   blk_t;
   typedef logic [10:0][127:0] rks_t;
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_LAST, S_DONE} fsm_e;

   // Byte 0 of a block is the most significant byte; AES state is column-major.
   function automatic logic [3:0] bi(input int b);
      return 4'(15 - b);
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] t;
      p = 8'h00;
      t = a;
      for (int i = 0; i < 8; i++) begin
         if (b[3'(i)]) p = p ^ t;
         t = xtime(t);
      end
      return p;
   endfunction

   // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] x3, x7, x15, x31, x63, x127;
      x3   = gf_mul(gf_mul(x, x), x);
      x7   = gf_mul(gf_mul(x3, x3), x);
      x15  = gf_mul(gf_mul(x7, x7), x);
      x31  = gf_mul(gf_mul(x15, x15), x);
      x63  = gf_mul(gf_mul(x31, x31), x);
      x127 = gf_mul(gf_mul(x63, x63), x);
      return gf_mul(x127, x127);
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] s;
      logic [7:0] y;
      s = gf_inv(x);
      for (int i = 0; i < 8; i++)
         y[3'(i)] = s[3'(i)] ^ s[3'(i + 4)] ^ s[3'(i + 5)] ^ s[3'(i + 6)] ^ s[3'(i + 7)];
      return y ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] x);
      logic [7:0] b;
      for (int i = 0; i < 8; i++)
         b[3'(i)] = x[3'(i + 2)] ^ x[3'(i + 5)] ^ x[3'(i + 7)];
      return gf_inv(b ^ 8'h05);
   endfunction

   function automatic blk_t inv_shift_rows(input blk_t s);
      blk_t o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[bi(4 * c + r)] = s[bi(4 * ((c - r + 4) % 4) + r)];
      return o;
   endfunction

   function automatic blk_t inv_sub_bytes(input blk_t s);
      blk_t o;
      for (int i = 0; i < 16; i++)
         o[4'(i)] = inv_sbox(s[4'(i)]);
      return o;
   endfunction

   function automatic blk_t inv_mix_columns(input blk_t s);
      blk_t o;
      logic [7:0] a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[bi(4 * c)];
         a1 = s[bi(4 * c + 1)];
         a2 = s[bi(4 * c + 2)];
         a3 = s[bi(4 * c + 3)];
         o[bi(4 * c)]     = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
         o[bi(4 * c + 1)] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
         o[bi(4 * c + 2)] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
         o[bi(4 * c + 3)] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
      end
      return o;
   endfunction

   // Round key r occupies element r (bits 128*r +: 128).
   function automatic rks_t expand_key(input logic [127:0] k);
      logic [43:0][31:0] w;
      logic [31:0]       t;
      logic [7:0]        rcon;
      rks_t              rk;
      w[0] = k[127:96];
      w[1] = k[95:64];
      w[2] = k[63:32];
      w[3] = k[31:0];
      rcon = 8'h01;
      for (int i = 4; i < 44; i++) begin
         t = w[6'(i - 1)];
         if (i % 4 == 0) begin
            t    = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rcon, 24'h0};
            rcon = xtime(rcon);
         end
         w[6'(i)] = w[6'(i - 4)] ^ t;
      end
      for (int r = 0; r < 11; r++)
         rk[4'(r)] = {w[6'(4 * r)], w[6'(4 * r + 1)], w[6'(4 * r + 2)], w[6'(4 * r + 3)]};
      return rk;
   endfunction

   function automatic logic [127:0] last_round_key(input logic [127:0] k);
      rks_t rk;
      rk = expand_key(k);
      return rk[10];
   endfunction

   fsm_e         fsm_q, fsm_d;
   logic [127:0] state_q, state_d;
   logic [127:0] key_q, key_d;
   logic [127:0] pt_q, pt_d;
   logic [3:0]   rnd_q, rnd_d;
   logic         in_ready_q;
   logic         abort_w;

   rks_t         rk_w;
   logic [127:0] rk10_in_w;
   logic [127:0] sub_w;
   logic [127:0] run_w;
   logic [127:0] last_w;

`ifdef AES_DEC_ABORT_EN
   assign abort_w = abort;
`else
   assign abort_w = 1'b0;
`endif

   // The accept-cycle whitening must use the incoming key, since key_q is still stale then.
   assign rk_w      = expand_key(key_q);
   assign rk10_in_w = last_round_key(key);
   assign sub_w     = inv_sub_bytes(inv_shift_rows(state_q));
   assign run_w     = inv_mix_columns(sub_w ^ rk_w[rnd_q]);
   assign last_w    = sub_w ^ rk_w[0];

   always_comb begin
      fsm_d   = fsm_q;
      state_d = state_q;
      key_d   = key_q;
      rnd_d   = rnd_q;
      pt_d    = pt_q;
      case (fsm_q)
         S_IDLE: begin
            if (in_valid && in_ready_q) begin
               key_d   = key;
               state_d = ciphertext ^ rk10_in_w;
               rnd_d   = 4'd9;
               fsm_d   = S_RUN;
            end
         end
         S_RUN: begin
            state_d = run_w;
            rnd_d   = rnd_q - 4'd1;
            if (rnd_q == 4'd1) fsm_d = S_LAST;
         end
         S_LAST: begin
            pt_d  = last_w;
            fsm_d = S_DONE;
         end
         S_DONE: begin
            if (out_ready) fsm_d = S_IDLE;
         end
         default: fsm_d = S_IDLE;
      endcase
      if (abort_w && (fsm_q != S_IDLE)) begin
         fsm_d   = S_IDLE;
         state_d = '0;
         rnd_d   = 4'd0;
         pt_d    = pt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fsm_q      <= S_IDLE;
         state_q    <= '0;
         key_q      <= '0;
         pt_q       <= '0;
         rnd_q      <= 4'd0;
         in_ready_q <= 1'b0;
      end else begin
         fsm_q      <= fsm_d;
         state_q    <= state_d;
         key_q      <= key_d;
         pt_q       <= pt_d;
         rnd_q      <= rnd_d;
         in_ready_q <= (fsm_d == S_IDLE);
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = (fsm_q == S_DONE);
   assign busy      = (fsm_q == S_RUN) || (fsm_q == S_LAST);
   assign plaintext = pt_q;

   always_comb begin
      round_idx = 4'd0;
      case (fsm_q)
         S_IDLE:         round_idx = 4'd10;
         S_RUN, S_LAST:  round_idx = rnd_q;
         default:        round_idx = 4'd0;
      endcase
   end

endmodule
